// File: rtl/buffer_pkg.sv
// Shared constants and helpers for the circular parallel-access buffer and its controller.
// Used by buffer_ctrl and wrap_ptr; the optional flush port is enabled with BUFCTRL_FLUSH_EN.
package buffer_pkg;

  localparam int DEF_MEM_SIZE  = 8;
  localparam int DEF_PAR_WRITE = 4;
  localparam int DEF_PAR_READ  = 2;

  // Occupancy must represent 0..mem_size inclusive, hence the +1.
  function automatic int cnt_width(input int mem_size);
    return $clog2(mem_size + 1);
  endfunction

  function automatic int wrap_add(input int ptr, input int step, input int modulus);
    int sum;
    sum = ptr + step;
    return (sum >= modulus) ? (sum - modulus) : sum;
  endfunction

endpackage

// File: rtl/wrap_ptr.sv
// Registered address pointer that advances by STEP modulo MODULUS when en_i is high.
// With BUFCTRL_FLUSH_EN defined, clr_i synchronously returns the pointer to 0.
module wrap_ptr
  import buffer_pkg::*;
#(
  parameter int W       = 3,
  parameter int STEP    = 1,
  parameter int MODULUS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
`ifdef BUFCTRL_FLUSH_EN
  input  logic         clr_i,
`endif
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = W'(wrap_add(int'(ptr_q), STEP, MODULUS));
    end
`ifdef BUFCTRL_FLUSH_EN
    if (clr_i) begin
      ptr_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/buffer_ctrl.sv
// Pointer and occupancy controller for the circular parallel-access buffer.
// Define BUFCTRL_FLUSH_EN to add the synchronous flush input.
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int MEM_SIZE    = DEF_MEM_SIZE,
  parameter int PAR_WRITE   = DEF_PAR_WRITE,
  parameter int PAR_READ    = DEF_PAR_READ,
  parameter int ADDRES_SIZE = $clog2(MEM_SIZE),
  parameter int CNT_SIZE    = cnt_width(MEM_SIZE),
  parameter int AFULL_LVL   = MEM_SIZE - PAR_WRITE
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef BUFCTRL_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   wr_req,
  output logic                   wr_ready,
  input  logic                   rd_req,
  output logic                   rd_valid,
  output logic                   wen,
  output logic [ADDRES_SIZE-1:0] waddr,
  output logic [ADDRES_SIZE-1:0] raddr,
  output logic [CNT_SIZE-1:0]    count,
  output logic                   full,
  output logic                   empty,
  output logic                   afull
);

  localparam int CW = CNT_SIZE + 1;
  localparam logic [CW-1:0]       WR_STEP   = CW'(PAR_WRITE);
  localparam logic [CW-1:0]       RD_STEP   = CW'(PAR_READ);
  localparam logic [CNT_SIZE-1:0] WR_LIMIT  = CNT_SIZE'(MEM_SIZE - PAR_WRITE);
  localparam logic [CNT_SIZE-1:0] RD_LIMIT  = CNT_SIZE'(PAR_READ);
  localparam logic [CNT_SIZE-1:0] FULL_LVL  = CNT_SIZE'(MEM_SIZE);
  localparam logic [CNT_SIZE-1:0] AFULL_THR = CNT_SIZE'(AFULL_LVL);

  logic                wr_acc;
  logic                rd_acc;
  logic                clear;
  logic [CNT_SIZE-1:0] count_q;
  logic [CNT_SIZE-1:0] count_d;
  logic [CW-1:0]       count_ext;
  logic                unused_count_msb;

`ifdef BUFCTRL_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // Status depends only on the registered count, so requests never loop back into ready/valid.
  assign wr_ready = (count_q <= WR_LIMIT);
  assign rd_valid = (count_q >= RD_LIMIT);
  assign full     = (count_q == FULL_LVL);
  assign empty    = (count_q == '0);
  assign afull    = (count_q >= AFULL_THR);

  assign wr_acc = wr_req & wr_ready;
  assign rd_acc = rd_req & rd_valid;
  assign wen    = wr_acc & ~rst & ~clear;

  always_comb begin
    count_ext = {1'b0, count_q};
    if (wr_acc) begin
      count_ext = count_ext + WR_STEP;
    end
    if (rd_acc) begin
      count_ext = count_ext - RD_STEP;
    end
    count_d = count_ext[CNT_SIZE-1:0];
    if (clear) begin
      count_d = '0;
    end
  end

  // The thresholds keep the result within 0..MEM_SIZE, so the guard bit is never set.
  assign unused_count_msb = count_ext[CNT_SIZE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  wrap_ptr #(
    .W       (ADDRES_SIZE),
    .STEP    (PAR_WRITE),
    .MODULUS (MEM_SIZE)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (wr_acc),
`ifdef BUFCTRL_FLUSH_EN
    .clr_i (flush),
`endif
    .ptr_o (waddr)
  );

  wrap_ptr #(
    .W       (ADDRES_SIZE),
    .STEP    (PAR_READ),
    .MODULUS (MEM_SIZE)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (rd_acc),
`ifdef BUFCTRL_FLUSH_EN
    .clr_i (flush),
`endif
    .ptr_o (raddr)
  );

endmodule

// File: tb/tb_buffer_ctrl.sv
// Bench for buffer_ctrl: a default 8/4/2 instance and a non-power-of-two 6/3/2 instance,
// both compared every cycle against a word-count model of the buffer occupancy and addresses.
module tb_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wrReq [2];
  logic       rdReq [2];

  logic       wrReady0, rdValid0, wen0, full0, empty0, afull0;
  logic [2:0] waddr0, raddr0;
  logic [3:0] count0;
  logic       wrReady1, rdValid1, wen1, full1, empty1, afull1;
  logic [2:0] waddr1, raddr1;
  logic [2:0] count1;

  int MS [2] = '{8, 6};
  int PW [2] = '{4, 3};
  int PR [2] = '{2, 2};
  int mc [2];
  int mw [2];
  int mr [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buffer_ctrl dut0 (
    .clk      (clk),
    .rst      (rst),
`ifdef BUFCTRL_FLUSH_EN
    .flush    (flush),
`endif
    .wr_req   (wrReq[0]),
    .wr_ready (wrReady0),
    .rd_req   (rdReq[0]),
    .rd_valid (rdValid0),
    .wen      (wen0),
    .waddr    (waddr0),
    .raddr    (raddr0),
    .count    (count0),
    .full     (full0),
    .empty    (empty0),
    .afull    (afull0)
  );

  buffer_ctrl #(
    .MEM_SIZE  (6),
    .PAR_WRITE (3),
    .PAR_READ  (2)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
`ifdef BUFCTRL_FLUSH_EN
    .flush    (flush),
`endif
    .wr_req   (wrReq[1]),
    .wr_ready (wrReady1),
    .rd_req   (rdReq[1]),
    .rd_valid (rdValid1),
    .wen      (wen1),
    .waddr    (waddr1),
    .raddr    (raddr1),
    .count    (count1),
    .full     (full1),
    .empty    (empty1),
    .afull    (afull1)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0;
      mw[k] = 0;
      mr[k] = 0;
    end
  endtask

  // Compare every output of instance k against the model's view of the current cycle.
  task automatic checkAll(input int k);
    int rdy, vld, wenE;
    int oWen, oWa, oRa, oCnt, oRdy, oVld, oFull, oEmpty, oAfull;
    rdy  = (mc[k] <= MS[k] - PW[k]) ? 1 : 0;
    vld  = (mc[k] >= PR[k]) ? 1 : 0;
    wenE = (wrReq[k] && rdy == 1 && !flush && !rst) ? 1 : 0;
    if (k == 0) begin
      oWen = int'(wen0); oWa = int'(waddr0); oRa = int'(raddr0); oCnt = int'(count0);
      oRdy = int'(wrReady0); oVld = int'(rdValid0); oFull = int'(full0);
      oEmpty = int'(empty0); oAfull = int'(afull0);
    end else begin
      oWen = int'(wen1); oWa = int'(waddr1); oRa = int'(raddr1); oCnt = int'(count1);
      oRdy = int'(wrReady1); oVld = int'(rdValid1); oFull = int'(full1);
      oEmpty = int'(empty1); oAfull = int'(afull1);
    end
    checkOutput($sformatf("d%0d.wen", k), oWen, wenE);
    checkOutput($sformatf("d%0d.waddr", k), oWa, mw[k]);
    checkOutput($sformatf("d%0d.raddr", k), oRa, mr[k]);
    checkOutput($sformatf("d%0d.count", k), oCnt, mc[k]);
    checkOutput($sformatf("d%0d.wr_ready", k), oRdy, rdy);
    checkOutput($sformatf("d%0d.rd_valid", k), oVld, vld);
    checkOutput($sformatf("d%0d.full", k), oFull, (mc[k] == MS[k]) ? 1 : 0);
    checkOutput($sformatf("d%0d.empty", k), oEmpty, (mc[k] == 0) ? 1 : 0);
    checkOutput($sformatf("d%0d.afull", k), oAfull, (mc[k] >= MS[k] - PW[k]) ? 1 : 0);
  endtask

  task automatic updateModel();
    int wa, ra;
    for (int k = 0; k < 2; k++) begin
      wa = (wrReq[k] && mc[k] <= MS[k] - PW[k]) ? 1 : 0;
      ra = (rdReq[k] && mc[k] >= PR[k]) ? 1 : 0;
      if (flush) begin
        mc[k] = 0;
        mw[k] = 0;
        mr[k] = 0;
      end else begin
        mw[k] = (mw[k] + wa * PW[k]) % MS[k];
        mr[k] = (mr[k] + ra * PR[k]) % MS[k];
        mc[k] = mc[k] + wa * PW[k] - ra * PR[k];
      end
    end
  endtask

  // Called at a falling edge: drive, check combinational outputs, then cross one rising edge.
  task automatic applyStimulus(input bit w0, input bit r0, input bit w1, input bit r1, input bit f);
    wrReq[0] = w0;
    rdReq[0] = r0;
    wrReq[1] = w1;
    rdReq[1] = r1;
    flush    = f;
    #1;
    checkAll(0);
    checkAll(1);
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of a write beat; wen must already be low.
  task automatic pulseReset();
    wrReq[0] = 1'b1;
    wrReq[1] = 1'b1;
    rdReq[0] = 1'b0;
    rdReq[1] = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    #1;
    resetModel();
    checkAll(0);
    checkAll(1);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    wrReq[0] = 1'b0;
    wrReq[1] = 1'b0;
  endtask

  initial begin
    bit f;
    rst      = 1'b1;
    flush    = 1'b0;
    wrReq[0] = 1'b0;
    wrReq[1] = 1'b0;
    rdReq[0] = 1'b0;
    rdReq[1] = 1'b0;
    resetModel();
    @(negedge clk);
    @(negedge clk);
    checkAll(0);
    checkAll(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst.count", int'(count0), 0);
    checkOutput("rst.empty", int'(empty0), 1);
    checkOutput("rst.wr_ready", int'(wrReady0), 1);

    // Fill both instances; the default one wraps waddr 4 -> 0 and goes full.
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("fill.count", int'(count0), 8);
    checkOutput("fill.full", int'(full0), 1);
    checkOutput("fill.wr_ready", int'(wrReady0), 0);
    checkOutput("fill.waddr", int'(waddr0), 0);
    checkOutput("np2.count", int'(count1), 6);

    // Drain with one extra read that must be ignored.
    repeat (5) applyStimulus(0, 1, 0, 1, 0);
    checkOutput("drain.raddr", int'(raddr0), 0);
    checkOutput("drain.empty", int'(empty0), 1);
    checkOutput("np2.raddr", int'(raddr1), 0);

    // Reach count=2, raddr=6, waddr=0, then write and read together.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("setup.count", int'(count0), 2);
    checkOutput("setup.raddr", int'(raddr0), 6);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("both.count", int'(count0), 4);
    checkOutput("both.waddr", int'(waddr0), 4);
    checkOutput("both.raddr", int'(raddr0), 0);

    pulseReset();
    checkOutput("midrst.count", int'(count0), 0);

`ifdef BUFCTRL_FLUSH_EN
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("flush.count", int'(count0), 0);
    checkOutput("flush.waddr", int'(waddr0), 0);
`endif

    repeat (1500) begin
      if ($urandom_range(0, 99) == 0) begin
        pulseReset();
      end else begin
        f = 1'b0;
`ifdef BUFCTRL_FLUSH_EN
        f = ($urandom_range(0, 15) == 0);
`endif
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
